// File: rtl/bfm_ahbl_arbiter.sv
// Two-master AHB-Lite arbiter BFM. Each master port has a one-deep hold
// register. A captured transfer is reissued to the single slave as NONSEQ
// SINGLE when its port owns the address phase. Ownership is round-robin and
// can be held by HMASTLOCK.
module bfm_ahbl_arbiter #(
    parameter int LOCK_EN = 1,
    parameter int TPD     = 1
) (
    input  logic        HCLK,
    input  logic        HRESETN,
    // master port 0
    input  logic [31:0] HADDR_M0,
    input  logic [1:0]  HTRANS_M0,
    input  logic        HWRITE_M0,
    input  logic [2:0]  HSIZE_M0,
    input  logic [2:0]  HBURST_M0,
    input  logic [3:0]  HPROT_M0,
    input  logic        HMASTLOCK_M0,
    input  logic [31:0] HWDATA_M0,
    output logic [31:0] HRDATA_M0,
    output logic        HREADY_M0,
    output logic        HRESP_M0,
    // master port 1
    input  logic [31:0] HADDR_M1,
    input  logic [1:0]  HTRANS_M1,
    input  logic        HWRITE_M1,
    input  logic [2:0]  HSIZE_M1,
    input  logic [2:0]  HBURST_M1,
    input  logic [3:0]  HPROT_M1,
    input  logic        HMASTLOCK_M1,
    input  logic [31:0] HWDATA_M1,
    output logic [31:0] HRDATA_M1,
    output logic        HREADY_M1,
    output logic        HRESP_M1,
    // slave side
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic        HMASTLOCK,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADYIN,
    input  logic        HRESP,
    output logic        HMASTER
);

    // TPD is a simulation-only output delay; it and the burst type and
    // HTRANS[0] have no functional effect here, since every issued
    // transfer is SINGLE.
    logic [31:0] unused_tpd;
    logic        unused_bits;
    assign unused_tpd  = 32'(TPD);
    assign unused_bits = ^{HBURST_M0, HBURST_M1, HTRANS_M0[0], HTRANS_M1[0]};

    logic [31:0] m_addr  [2];
    logic [2:0]  m_size  [2];
    logic [3:0]  m_prot  [2];
    logic [31:0] m_wdata [2];
    logic [1:0]  m_req, m_write, m_lock;

    assign m_addr[0]  = HADDR_M0;
    assign m_addr[1]  = HADDR_M1;
    assign m_size[0]  = HSIZE_M0;
    assign m_size[1]  = HSIZE_M1;
    assign m_prot[0]  = HPROT_M0;
    assign m_prot[1]  = HPROT_M1;
    assign m_wdata[0] = HWDATA_M0;
    assign m_wdata[1] = HWDATA_M1;
    assign m_req      = {HTRANS_M1[1], HTRANS_M0[1]};
    assign m_write    = {HWRITE_M1, HWRITE_M0};
    assign m_lock     = {HMASTLOCK_M1, HMASTLOCK_M0};

    logic [31:0] cap_addr [2];
    logic [2:0]  cap_size [2];
    logic [3:0]  cap_prot [2];
    logic [1:0]  cap_write, cap_lock;
    logic [1:0]  pend, pend_nxt, hready, hresp, capture;
    logic        amaster, amaster_nxt, last_grant, last_grant_nxt;
    logic        dvalid, downer, lock_hold, lock_nxt;
    logic        issue, accept, may_switch;

    assign issue  = pend[amaster];
    assign accept = issue & HREADYIN;

    // Per-port ready/response: the data-phase owner follows the slave,
    // a port with a held transfer stalls, otherwise the port is free.
    always_comb begin
        hready  = '0;
        hresp   = '0;
        for (int i = 0; i < 2; i++) begin
            if (dvalid && (downer == 1'(i))) begin
                hready[i] = HREADYIN;
                hresp[i]  = HRESP;
            end else begin
                hready[i] = ~pend[i];
            end
        end
        capture = hready & m_req;
    end

    // Next hold-register set, lock state and round-robin grant.
    always_comb begin
        pend_nxt       = pend;
        amaster_nxt    = amaster;
        last_grant_nxt = last_grant;
        for (int i = 0; i < 2; i++) begin
            if (capture[i])
                pend_nxt[i] = 1'b1;
            else if (accept && (amaster == 1'(i)))
                pend_nxt[i] = 1'b0;
        end
        // The transfer accepted at this edge decides the lock going forward.
        lock_nxt   = accept ? cap_lock[amaster] : lock_hold;
        may_switch = (HREADYIN || !pend[amaster]) && !((LOCK_EN != 0) && lock_nxt);
        if (may_switch) begin
            case (pend_nxt)
                2'b11: begin
                    amaster_nxt    = ~last_grant;
                    last_grant_nxt = ~last_grant;
                end
                2'b01: begin
                    amaster_nxt    = 1'b0;
                    last_grant_nxt = 1'b0;
                end
                2'b10: begin
                    amaster_nxt    = 1'b1;
                    last_grant_nxt = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Hold registers, address-phase owner and data-phase tracking.
    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            pend       <= '0;
            cap_addr   <= '{default: '0};
            cap_size   <= '{default: '0};
            cap_prot   <= '{default: '0};
            cap_write  <= '0;
            cap_lock   <= '0;
            amaster    <= 1'b0;
            last_grant <= 1'b1;
            dvalid     <= 1'b0;
            downer     <= 1'b0;
            lock_hold  <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (capture[i]) begin
                    cap_addr[i]  <= m_addr[i];
                    cap_size[i]  <= m_size[i];
                    cap_prot[i]  <= m_prot[i];
                    cap_write[i] <= m_write[i];
                    cap_lock[i]  <= m_lock[i];
                end
            end
            pend       <= pend_nxt;
            amaster    <= amaster_nxt;
            last_grant <= last_grant_nxt;
            lock_hold  <= lock_nxt;
            if (accept) begin
                dvalid <= 1'b1;
                downer <= amaster;
            end else if (HREADYIN) begin
                dvalid <= 1'b0;
            end
        end
    end

    assign HTRANS    = issue ? 2'b10 : 2'b00;
    assign HADDR     = cap_addr[amaster];
    assign HWRITE    = cap_write[amaster];
    assign HSIZE     = cap_size[amaster];
    assign HPROT     = cap_prot[amaster];
    assign HMASTLOCK = cap_lock[amaster];
    assign HBURST    = 3'b000;
    assign HMASTER   = amaster;
    assign HWDATA    = m_wdata[downer];

    assign HREADY_M0 = hready[0];
    assign HREADY_M1 = hready[1];
    assign HRESP_M0  = hresp[0];
    assign HRESP_M1  = hresp[1];
    assign HRDATA_M0 = HRDATA;
    assign HRDATA_M1 = HRDATA;

endmodule
